// File: rtl/nms_3x3_keypoint.sv
// Streaming 3x3 non-maximum suppression: flags pixels that are strict local maxima of
// their 3x3 neighbourhood and at least a threshold, on a valid-qualified raster stream.
module nms_3x3_keypoint #(
    parameter int unsigned width     = 420,
    parameter int unsigned threshold = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       blanking_in,
    input  logic       validin,
    output logic [7:0] dout,
    output logic       keypoint,
    output logic       blanking_out,
    output logic       validout
);

    localparam logic [8:0] XLast = 9'(width - 1);
    localparam logic [9:0] FDone = 10'(width + 1);
    localparam logic [7:0] Thr   = 8'(threshold);

    // Tap format: {blanking, pixel}
    logic [8:0] lb1_mem [width];
    logic [8:0] lb2_mem [width];

    logic [2:0][2:0][8:0] win_q, win_d;
    logic [8:0]           x_count_q, x_count_d;
    logic [9:0]           fill_q, fill_d;
    logic [7:0]           dout_q, dout_d;
    logic                 keypoint_q, keypoint_d;
    logic                 blanking_q, blanking_d;
    logic                 validout_q;

    logic [8:0] in_tap;
    logic [8:0] lb1_rd, lb2_rd;
    logic [8:0] centre;
    logic [8:0] cx;
    logic       blank_c;
    logic       nb_blank;
    logic       gt_all;

    assign in_tap = {blanking_in, blanking_in ? 8'd0 : din};
    assign lb1_rd = lb1_mem[x_count_q];
    assign lb2_rd = lb2_mem[x_count_q];

    // Line buffers carry no reset; the fill counter masks their stale contents.
    always_ff @(posedge clock) begin
        if (validin) begin
            lb1_mem[x_count_q] <= in_tap;
            lb2_mem[x_count_q] <= lb1_rd;
        end
    end

    always_comb begin
        win_d     = win_q;
        x_count_d = x_count_q;
        fill_d    = fill_q;
        if (validin) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][2] = win_q[r][1];
                win_d[r][1] = win_q[r][0];
            end
            win_d[2][0] = in_tap;
            win_d[1][0] = lb1_rd;
            win_d[0][0] = lb2_rd;
            x_count_d   = (x_count_q == XLast) ? 9'd0 : x_count_q + 9'd1;
            if (fill_q != FDone) begin
                fill_d = fill_q + 10'd1;
            end
        end
    end

    // Decisions are taken on the window as it will look after this sample shifts in.
    always_comb begin
        centre   = win_d[1][1];
        cx       = (x_count_q == 9'd0) ? XLast : x_count_q - 9'd1;
        blank_c  = centre[8] | (fill_q != FDone) | (cx == 9'd0) | (cx == XLast);
        nb_blank = 1'b0;
        gt_all   = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1)) begin
                    nb_blank = nb_blank | win_d[r][c][8];
                    gt_all   = gt_all & (centre[7:0] > win_d[r][c][7:0]);
                end
            end
        end
    end

    always_comb begin
        dout_d     = dout_q;
        keypoint_d = keypoint_q;
        blanking_d = blanking_q;
        if (validin) begin
            dout_d     = blank_c ? 8'd0 : centre[7:0];
            blanking_d = blank_c;
            keypoint_d = !blank_c && !nb_blank && (centre[7:0] >= Thr) && gt_all;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            win_q      <= {9{9'h100}};
            x_count_q  <= 9'd0;
            fill_q     <= 10'd0;
            dout_q     <= 8'd0;
            keypoint_q <= 1'b0;
            blanking_q <= 1'b1;
            validout_q <= 1'b0;
        end else begin
            win_q      <= win_d;
            x_count_q  <= x_count_d;
            fill_q     <= fill_d;
            dout_q     <= dout_d;
            keypoint_q <= keypoint_d;
            blanking_q <= blanking_d;
            validout_q <= validin;
        end
    end

    assign dout         = dout_q;
    assign keypoint     = keypoint_q;
    assign blanking_out = blanking_q;
    assign validout     = validout_q;

endmodule

// File: tb/tb_nms_3x3_keypoint.sv
// Directed bench for nms_3x3_keypoint: table of single-frame cases against a
// position-based neighbourhood model, plus reset and stall sequences.
module tb_nms_3x3_keypoint;

    localparam int W  = 420;
    localparam int TH = 16;
    localparam int NR = 8;
    localparam int NS = NR * W;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = 8'd0;
    logic       blanking_in = 1'b0;
    logic       validin = 1'b0;
    logic [7:0] dout;
    logic       keypoint;
    logic       blanking_out;
    logic       validout;

    nms_3x3_keypoint #(.width(W), .threshold(TH)) dut (
        .clock        (clock),
        .reset        (reset),
        .din          (din),
        .blanking_in  (blanking_in),
        .validin      (validin),
        .dout         (dout),
        .keypoint     (keypoint),
        .blanking_out (blanking_out),
        .validout     (validout)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [7:0] fp [NS];
    bit         fb [NS];

    logic [7:0] cap_dout  [$];
    bit         cap_kp    [$];
    bit         cap_blank [$];

    bit check_en  = 1'b0;
    bit exp_vout  = 1'b0;
    int trail_err = 0;

    always @(posedge clock) exp_vout <= reset ? validin : 1'b0;

    always @(negedge clock) begin
        if (check_en) begin
            if (validout !== exp_vout) trail_err++;
            if (validout === 1'b1) begin
                cap_dout.push_back(dout);
                cap_kp.push_back(keypoint);
                cap_blank.push_back(blanking_out);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Stream rows 0 and NR-1 are blanking rows; the image lives in rows 1..NR-2.
    task automatic build_frame(input int bg);
        for (int i = 0; i < NS; i++) begin
            fb[i] = (i < W) || (i >= (NR - 1) * W);
            fp[i] = fb[i] ? 8'd0 : 8'(bg);
        end
    endtask

    task automatic drive(input int n_stop, input bit stall);
        for (int i = 0; i < n_stop; i++) begin
            bit sent;
            sent = 1'b0;
            while (!sent) begin
                @(negedge clock);
                if (stall && $urandom_range(0, 1) == 0) begin
                    validin = 1'b0;
                end else begin
                    validin     = 1'b1;
                    din         = fp[i];
                    blanking_in = fb[i];
                    sent        = 1'b1;
                end
            end
        end
    endtask

    task automatic run_frame(input bit stall);
        cap_dout.delete();
        cap_kp.delete();
        cap_blank.delete();
        drive(NS, stall);
        @(negedge clock);
        validin = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    // Expected output for the k-th valid sample after reset.
    task automatic model(input int k, output logic [7:0] d, output bit kp, output bit bl);
        int s, c;
        bit ok;
        s  = k - (W + 1);
        d  = 8'd0;
        kp = 1'b0;
        bl = 1'b1;
        if (s >= 0) begin
            c  = s % W;
            bl = fb[s] || c == 0 || c == W - 1;
            d  = bl ? 8'd0 : fp[s];
            if (!bl) begin
                ok = fp[s] >= 8'(TH);
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int n;
                        n = s + dr * W + dc;
                        if (!(dr == 0 && dc == 0)) begin
                            if (n < 0 || fb[n] || fp[n] >= fp[s]) ok = 1'b0;
                        end
                    end
                end
                kp = ok;
            end
        end
    endtask

    task automatic check_frame(input string name);
        int mism, first, n;
        logic [7:0] d;
        bit kp, bl;
        mism  = 0;
        first = -1;
        n     = cap_dout.size();
        check({name, "_count"}, n, NS);
        for (int k = 0; k < NS && k < n; k++) begin
            model(k, d, kp, bl);
            if (cap_dout[k] !== d || cap_kp[k] !== kp || cap_blank[k] !== bl) begin
                mism++;
                if (first < 0) first = k;
            end
        end
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL %s_model: got %0d mismatching outputs (first at %0d) want 0",
                     name, mism, first);
        end
    endtask

    typedef struct {
        string name;
        int    r;          // peak stream row, -1 for none
        int    c;
        int    v;
        int    c2;         // second peak column in same row, -1 for none
        int    bg;
        bit    stall;
        int    exp_cnt;    // keypoints in the whole frame
        int    chk_idx;    // output index inspected by hand
        int    exp_dout;
        int    exp_blank;
        int    exp_kp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // Output index of a centre at stream (r,c) is r*W + c + W + 1.
        vecs[0] = '{"flat",       -1,   0,   0,  -1, 100, 1'b0, 0, 1686, 100, 0, 0};
        vecs[1] = '{"peak",        5,  10, 200,  -1,   0, 1'b0, 1, 2531, 200, 0, 1};
        vecs[2] = '{"thr15",       3,  50,  15,  -1,   0, 1'b0, 0, 1731,  15, 0, 0};
        vecs[3] = '{"thr16",       3,  50,  16,  -1,   0, 1'b0, 1, 1731,  16, 0, 1};
        vecs[4] = '{"tie",         3, 100, 200, 101,   0, 1'b0, 0, 1781, 200, 0, 0};
        vecs[5] = '{"col0",        3,   0, 200,  -1,   0, 1'b0, 0, 1681,   0, 1, 0};
        vecs[6] = '{"col419",      3, 419, 200,  -1,   0, 1'b0, 0, 2100,   0, 1, 0};
        vecs[7] = '{"toprow",      1,  50, 200,  -1,   0, 1'b0, 0,  891, 200, 0, 0};
        vecs[8] = '{"peak_stall",  5,  10, 200,  -1,   0, 1'b1, 1, 2531, 200, 0, 1};

        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_validout", int'(validout), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_keypoint", int'(keypoint), 0);
        check("rst_blanking", int'(blanking_out), 1);
        reset    = 1'b1;
        check_en = 1'b1;

        foreach (vecs[i]) begin
            int cnt;
            build_frame(vecs[i].bg);
            if (vecs[i].r >= 0) fp[vecs[i].r * W + vecs[i].c] = 8'(vecs[i].v);
            if (vecs[i].c2 >= 0) fp[vecs[i].r * W + vecs[i].c2] = 8'(vecs[i].v);
            // Each case starts from a fresh stream.
            @(negedge clock);
            reset = 1'b0;
            @(negedge clock);
            reset = 1'b1;
            run_frame(vecs[i].stall);
            check_frame(vecs[i].name);
            cnt = 0;
            foreach (cap_kp[k]) cnt += int'(cap_kp[k]);
            check({vecs[i].name, "_kpcount"}, cnt, vecs[i].exp_cnt);
            if (cap_dout.size() > vecs[i].chk_idx) begin
                check({vecs[i].name, "_dout"}, int'(cap_dout[vecs[i].chk_idx]), vecs[i].exp_dout);
                check({vecs[i].name, "_blank"}, int'(cap_blank[vecs[i].chk_idx]),
                      vecs[i].exp_blank);
                check({vecs[i].name, "_kp"}, int'(cap_kp[vecs[i].chk_idx]), vecs[i].exp_kp);
            end else begin
                check({vecs[i].name, "_short"}, cap_dout.size(), vecs[i].chk_idx + 1);
            end
        end

        // Reset mid-frame at stream row 3, with validin held high through it.
        build_frame(0);
        fp[3 * W + 40] = 8'd200;
        drive(3 * W + 7, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_validout", int'(validout), 0);
        check("midrst_blanking", int'(blanking_out), 1);
        check("midrst_keypoint", int'(keypoint), 0);
        reset   = 1'b1;
        validin = 1'b0;
        @(negedge clock);
        build_frame(0);
        fp[5 * W + 10] = 8'd200;
        run_frame(1'b0);
        check_frame("midrst_frame");
        begin
            int nb;
            nb = 0;
            for (int k = 0; k < W + 1 && k < cap_blank.size(); k++) nb += int'(cap_blank[k]);
            check("midrst_fill_blank", nb, W + 1);
        end
        if (cap_kp.size() > 2531) check("midrst_peak", int'(cap_kp[2531]), 1);
        else check("midrst_short", cap_kp.size(), 2532);

        check("validout_trail", trail_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
